// File: rtl/dest_reg_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dest_reg_tracker_pkg
//  Purpose  : Shared constants and types for the destination-register tracker:
//             default register address width, operand-forward select encodings
//             and pipeline entry field widths.
//  Revision : 1.0  initial release
// ============================================================================
package dest_reg_tracker_pkg;

    // Default register address width (32 architectural registers).
    localparam int REG_AW = 5;

    // Operand-forward select encoding seen by the EX-stage operand muxes.
    typedef logic [1:0] fwd_t;
    localparam fwd_t FWD_RF  = 2'b00;   // take operand from the register file
    localparam fwd_t FWD_WB  = 2'b01;   // take operand from the WB-stage result
    localparam fwd_t FWD_MEM = 2'b10;   // take operand from the MEM-stage result

    // Tracked entry is {valid, dest, load}.
    localparam int ENTRY_VALID_W = 1;
    localparam int ENTRY_LOAD_W  = 1;

endpackage : dest_reg_tracker_pkg
`default_nettype wire

// File: rtl/dest_reg_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module   : dest_reg_tracker_if
//  Purpose  : Pipeline-side bundle of the destination-register tracker.
//  Ports    : master - pipeline control (drives EX/ID fields and freeze,
//                      receives forward selects, stall and WB address)
//             slave  - the tracker itself
//  Revision : 1.0  initial release
// ============================================================================
interface dest_reg_tracker_if
    import dest_reg_tracker_pkg::*;
#(
    parameter int REG_AW = dest_reg_tracker_pkg::REG_AW
);
    logic              freeze;
    logic [REG_AW-1:0] ex_dest;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    fwd_t              fwd_a;
    fwd_t              fwd_b;
    logic              stall;
    logic [REG_AW-1:0] mem_dest;
    logic [REG_AW-1:0] wb_dest;
    logic              wb_write;

    modport master (
        output freeze, ex_dest, ex_reg_write, ex_mem_read, ex_rs, ex_rt,
               id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  fwd_a, fwd_b, stall, mem_dest, wb_dest, wb_write
    );

    modport slave (
        input  freeze, ex_dest, ex_reg_write, ex_mem_read, ex_rs, ex_rt,
               id_rs, id_rt, id_uses_rs, id_uses_rt,
        output fwd_a, fwd_b, stall, mem_dest, wb_dest, wb_write
    );

endinterface : dest_reg_tracker_if
`default_nettype wire

// File: rtl/dest_reg_tracker_stage.sv
`default_nettype none
// ============================================================================
//  Module   : dest_stage_reg
//  Purpose  : One pipeline entry {valid, dest, load}. Loads d_* when en is
//             high, holds otherwise; rst_n clears the entry synchronously.
//  Ports    : clk, rst_n (sync, active low), en,
//             d_valid/d_dest/d_load in, q_valid/q_dest/q_load out
//  Revision : 1.0  initial release
// ============================================================================
module dest_stage_reg #(
    parameter int REG_AW = 5
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              en,
    input  wire logic              d_valid,
    input  wire logic [REG_AW-1:0] d_dest,
    input  wire logic              d_load,
    output logic                   q_valid,
    output logic      [REG_AW-1:0] q_dest,
    output logic                   q_load
);

    logic              r_valid;
    logic [REG_AW-1:0] r_dest;
    logic              r_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_dest  <= '0;
            r_load  <= 1'b0;
        end else if (en) begin
            r_valid <= d_valid;
            r_dest  <= d_dest;
            r_load  <= d_load;
        end
    end

    assign q_valid = r_valid;
    assign q_dest  = r_dest;
    assign q_load  = r_load;

endmodule : dest_stage_reg
`default_nettype wire

// File: rtl/dest_reg_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : dest_reg_tracker
//  Purpose  : Carries the EX-stage write destination through MEM and WB,
//             produces EX operand-forward selects, the ID load-use stall and
//             the register-file write address, and counts stall cycles.
//  Ports    : clk          - clock, rising edge
//             rst_n        - synchronous reset, active low
//             bus          - dest_reg_tracker_if.slave (EX/ID inputs, freeze,
//                            fwd_a/fwd_b, stall, mem_dest, wb_dest, wb_write)
//             stall_count  - saturating count of stall cycles since reset
//  Revision : 1.0  initial release
// ============================================================================
module dest_reg_tracker
    import dest_reg_tracker_pkg::*;
#(
    parameter int REG_AW = dest_reg_tracker_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    dest_reg_tracker_if.slave     bus,
    output logic      [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic              w_ex_valid;
    logic              w_shift;
    logic              w_mem_valid;
    logic [REG_AW-1:0] w_mem_dest;
    logic              w_mem_load;
    logic              w_wb_valid;
    logic [REG_AW-1:0] w_wb_dest;
    logic              w_wb_load;
    logic              w_stall;
    fwd_t              w_fwd_a;
    fwd_t              w_fwd_b;
    logic [CNT_W-1:0]  r_stall_count;

    // Writes to $0 are architecturally discarded, so they are never tracked.
    assign w_ex_valid = bus.ex_reg_write && (bus.ex_dest != '0);
    assign w_shift    = !bus.freeze;

    dest_stage_reg #(.REG_AW(REG_AW)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (w_shift),
        .d_valid (w_ex_valid),
        .d_dest  (bus.ex_dest),
        .d_load  (bus.ex_mem_read),
        .q_valid (w_mem_valid),
        .q_dest  (w_mem_dest),
        .q_load  (w_mem_load)
    );

    dest_stage_reg #(.REG_AW(REG_AW)) u_wb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (w_shift),
        .d_valid (w_mem_valid),
        .d_dest  (w_mem_dest),
        .d_load  (w_mem_load),
        .q_valid (w_wb_valid),
        .q_dest  (w_wb_dest),
        .q_load  (w_wb_load)
    );

    // MEM wins over WB as it holds the younger result. A load in MEM has no
    // data yet, so it never forwards; the load-use stall keeps that case away.
    function automatic fwd_t fwd_sel(input logic [REG_AW-1:0] src);
        fwd_t sel;
        sel = FWD_RF;
        if (src != '0) begin
            if (w_mem_valid && !w_mem_load && (w_mem_dest == src))
                sel = FWD_MEM;
            else if (w_wb_valid && (w_wb_dest == src))
                sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        w_fwd_a = FWD_RF;
        w_fwd_b = FWD_RF;
        w_fwd_a = fwd_sel(bus.ex_rs);
        w_fwd_b = fwd_sel(bus.ex_rt);
    end

    // w_ex_valid already excludes $0, so a load to $0 never stalls.
    assign w_stall = bus.ex_mem_read && w_ex_valid &&
                     ((bus.id_uses_rs && (bus.id_rs == bus.ex_dest)) ||
                      (bus.id_uses_rt && (bus.id_rt == bus.ex_dest)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && w_shift && (r_stall_count != C_CNT_MAX)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign bus.fwd_a    = w_fwd_a;
    assign bus.fwd_b    = w_fwd_b;
    assign bus.stall    = w_stall;
    assign bus.mem_dest = w_mem_dest;
    assign bus.wb_dest  = w_wb_dest;
    assign bus.wb_write = w_wb_valid;
    assign stall_count  = r_stall_count;

    logic w_unused;
    assign w_unused = w_wb_load;

endmodule : dest_reg_tracker
`default_nettype wire

// File: tb/tb_dest_reg_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dest_reg_tracker
//  Purpose  : Directed self-checking bench for dest_reg_tracker. u_dut uses
//             the default counter width; u_dut4 uses a 4-bit counter to
//             exercise saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dest_reg_tracker;

    logic        clk;
    logic        rst_n;
    logic [15:0] cnt0;
    logic [3:0]  cnt4;
    int          vectors;
    int          miscompares;

    dest_reg_tracker_if bus0 ();
    dest_reg_tracker_if bus4 ();

    dest_reg_tracker #(.CNT_W(16)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus0),
        .stall_count (cnt0)
    );

    dest_reg_tracker #(.CNT_W(4)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus4),
        .stall_count (cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ex0(input logic [4:0] dest, input logic wr, input logic rd,
                           input logic [4:0] rs, input logic [4:0] rt);
        bus0.ex_dest      = dest;
        bus0.ex_reg_write = wr;
        bus0.ex_mem_read  = rd;
        bus0.ex_rs        = rs;
        bus0.ex_rt        = rt;
    endtask

    task automatic set_id0(input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt);
        bus0.id_rs      = rs;
        bus0.id_rt      = rt;
        bus0.id_uses_rs = urs;
        bus0.id_uses_rt = urt;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus0.freeze = 1'b0;
        set_ex0(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        set_id0(5'd0, 5'd0, 1'b0, 1'b0);
        bus4.freeze = 1'b0;
        bus4.ex_dest = 5'd0; bus4.ex_reg_write = 1'b0; bus4.ex_mem_read = 1'b0;
        bus4.ex_rs = 5'd0; bus4.ex_rt = 5'd0;
        bus4.id_rs = 5'd0; bus4.id_rt = 5'd0;
        bus4.id_uses_rs = 1'b0; bus4.id_uses_rt = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // ---- 1: populate MEM/WB and the counter, then reset (with freeze high)
        set_ex0(5'd3, 1'b1, 1'b1, 5'd0, 5'd0);
        set_id0(5'd3, 5'd0, 1'b1, 1'b0);
        settle();
        chk("t1_stall_pre", 32'(bus0.stall), 32'd1);
        tick();
        chk("t1_mem_dest_pre", 32'(bus0.mem_dest), 32'd3);
        chk("t1_cnt_pre", 32'(cnt0), 32'd1);
        set_ex0(5'd3, 1'b1, 1'b0, 5'd0, 5'd0);
        set_id0(5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("t1_wb_write_pre", 32'(bus0.wb_write), 32'd1);
        chk("t1_wb_dest_pre", 32'(bus0.wb_dest), 32'd3);
        rst_n       = 1'b0;
        bus0.freeze = 1'b1;
        bus0.ex_rs  = 5'd3;
        tick();
        tick();
        chk("t1_mem_dest", 32'(bus0.mem_dest), 32'd0);
        chk("t1_wb_dest", 32'(bus0.wb_dest), 32'd0);
        chk("t1_wb_write", 32'(bus0.wb_write), 32'd0);
        chk("t1_cnt", 32'(cnt0), 32'd0);
        chk("t1_fwd_a", 32'(bus0.fwd_a), 32'd0);
        chk("t1_stall", 32'(bus0.stall), 32'd0);
        rst_n       = 1'b1;
        bus0.freeze = 1'b0;
        set_ex0(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);

        // ---- 2: forward from MEM, then from WB
        set_ex0(5'd8, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        set_ex0(5'd0, 1'b0, 1'b0, 5'd8, 5'd0);
        settle();
        chk("t2_fwd_a_mem", 32'(bus0.fwd_a), 32'd2);
        chk("t2_fwd_b_none", 32'(bus0.fwd_b), 32'd0);
        tick();
        set_ex0(5'd0, 1'b0, 1'b0, 5'd8, 5'd8);
        settle();
        chk("t2_fwd_a_wb", 32'(bus0.fwd_a), 32'd1);
        chk("t2_fwd_b_wb", 32'(bus0.fwd_b), 32'd1);
        chk("t2_wb_dest", 32'(bus0.wb_dest), 32'd8);
        chk("t2_wb_write", 32'(bus0.wb_write), 32'd1);
        chk("t2_mem_dest", 32'(bus0.mem_dest), 32'd0);

        // ---- 3: load-use stall, bubble, then forward from WB
        set_ex0(5'd5, 1'b1, 1'b1, 5'd0, 5'd0);
        set_id0(5'd0, 5'd5, 1'b0, 1'b1);
        settle();
        chk("t3_stall", 32'(bus0.stall), 32'd1);
        tick();
        chk("t3_cnt", 32'(cnt0), 32'd1);
        set_ex0(5'd0, 1'b0, 1'b0, 5'd0, 5'd5);
        settle();
        chk("t3_stall_bubble", 32'(bus0.stall), 32'd0);
        chk("t3_fwd_b_memload", 32'(bus0.fwd_b), 32'd0);
        tick();
        chk("t3_fwd_b_wb", 32'(bus0.fwd_b), 32'd1);
        chk("t3_cnt_hold", 32'(cnt0), 32'd1);
        set_id0(5'd0, 5'd0, 1'b0, 1'b0);

        // ---- 4: writes and loads to $0 are ignored
        set_ex0(5'd0, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        tick();
        chk("t4_fwd_a", 32'(bus0.fwd_a), 32'd0);
        chk("t4_wb_write", 32'(bus0.wb_write), 32'd0);
        set_ex0(5'd0, 1'b1, 1'b1, 5'd0, 5'd0);
        set_id0(5'd0, 5'd0, 1'b1, 1'b1);
        settle();
        chk("t4_stall_r0", 32'(bus0.stall), 32'd0);
        set_ex0(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        set_id0(5'd0, 5'd0, 1'b0, 1'b0);

        // ---- 5: MEM priority, then freeze holds everything
        set_ex0(5'd9, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        tick();
        bus0.ex_rs = 5'd9;
        settle();
        chk("t5_fwd_a_prio", 32'(bus0.fwd_a), 32'd2);
        bus0.freeze = 1'b1;
        set_ex0(5'd7, 1'b1, 1'b1, 5'd9, 5'd0);
        set_id0(5'd7, 5'd0, 1'b1, 1'b0);
        settle();
        chk("t5_stall_frozen", 32'(bus0.stall), 32'd1);
        tick();
        tick();
        tick();
        chk("t5_mem_dest", 32'(bus0.mem_dest), 32'd9);
        chk("t5_wb_dest", 32'(bus0.wb_dest), 32'd9);
        chk("t5_wb_write", 32'(bus0.wb_write), 32'd1);
        chk("t5_cnt", 32'(cnt0), 32'd1);
        chk("t5_fwd_a", 32'(bus0.fwd_a), 32'd2);
        set_ex0(5'd0, 1'b0, 1'b0, 5'd9, 5'd0);
        set_id0(5'd0, 5'd0, 1'b0, 1'b0);
        bus0.freeze = 1'b0;
        tick();
        chk("t5_fwd_a_after", 32'(bus0.fwd_a), 32'd1);
        chk("t5_mem_dest_after", 32'(bus0.mem_dest), 32'd0);

        // ---- 6: 4-bit counter saturates at 15
        bus4.ex_dest = 5'd4; bus4.ex_reg_write = 1'b1; bus4.ex_mem_read = 1'b1;
        bus4.id_rs = 5'd4; bus4.id_uses_rs = 1'b1;
        settle();
        chk("t6_stall", 32'(bus4.stall), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        chk("t6_cnt10", 32'(cnt4), 32'd10);
        for (int i = 0; i < 10; i++) tick();
        chk("t6_cnt_sat", 32'(cnt4), 32'd15);
        chk("t6_cnt0_indep", 32'(cnt0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dest_reg_tracker
`default_nettype wire
